// File: rtl/sng_array.sv
`default_nettype none
// ============================================================================
// Module   : sng_array
// Purpose  : Multi-channel LFSR-based stochastic number generator with
//            per-channel ones counters. Optional macro SNG_SHARED_LFSR_EN
//            shares one LFSR across channels, using per-channel rotations.
// Revision : 1.0  initial release
// ============================================================================
module sng_array #(
  parameter int             N    = 10,
  parameter int             CH   = 2,
  parameter logic [N-1:0]   TAPS = 10'h240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH*N-1:0]   A,
  input  logic [CH*N-1:0]   seed,
  input  logic [N-1:0]      len,
  output logic              busy,
  output logic [CH-1:0]     Y,
  output logic              y_valid,
  output logic              done,
  output logic [CH*N-1:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [CH-1:0][N-1:0]  a_q;
  logic [CH-1:0][N-1:0]  count_q;
  logic [CH-1:0][N-1:0]  count_d;
  logic [CH-1:0][N-1:0]  lfsr_val;
  logic [N-1:0]          remain_q;
  logic [CH-1:0]         y_q;
  logic [CH-1:0]         cmp;
  logic                  y_valid_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  load;
  logic                  step;

  assign load = (state_q == S_IDLE) && start;
  assign step = (state_q == S_RUN);

  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] v);
    return {v[N-2:0], ^(v & TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [N-1:0] seed_fix(input logic [N-1:0] s);
    return (s == '0) ? {{(N-1){1'b0}}, 1'b1} : s;
  endfunction

`ifdef SNG_SHARED_LFSR_EN
  logic [N-1:0] lfsr_q;
  logic [N-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)      lfsr_d = seed_fix(seed[N-1:0]);
    else if (step) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= '0;
    else      lfsr_q <= lfsr_d;
  end

  // Rotation keeps the nonzero value set intact, so full-period counts stay exact.
  for (genvar c = 0; c < CH; c++) begin : g_rot
    localparam int SH = c % N;
    if (SH == 0) begin : g_id
      assign lfsr_val[c] = lfsr_q;
    end else begin : g_rl
      assign lfsr_val[c] = {lfsr_q[N-1-SH:0], lfsr_q[N-1:N-SH]};
    end
  end

  if (CH > 1) begin : g_seed_tie
    logic unused_seed;
    assign unused_seed = ^seed[CH*N-1:N];
  end
`else
  logic [CH-1:0][N-1:0] lfsr_q;
  logic [CH-1:0][N-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    for (int c = 0; c < CH; c++) begin
      if (load)      lfsr_d[c] = seed_fix(seed[c*N +: N]);
      else if (step) lfsr_d[c] = lfsr_next(lfsr_q[c]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= '0;
    else      lfsr_q <= lfsr_d;
  end

  assign lfsr_val = lfsr_q;
`endif

  always_comb begin
    cmp     = '0;
    count_d = count_q;
    for (int c = 0; c < CH; c++) begin
      cmp[c]     = (lfsr_val[c] <= a_q[c]);
      count_d[c] = count_q[c] + {{(N-1){1'b0}}, cmp[c]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      remain_q  <= '0;
      count_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= A;
            remain_q <= (len == '0) ? '1 : len;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            busy_q   <= 1'b0;
          end
        end
        S_RUN: begin
          y_q       <= cmp;
          y_valid_q <= 1'b1;
          count_q   <= count_d;
          remain_q  <= remain_q - 1'b1;
          if (remain_q == {{(N-1){1'b0}}, 1'b1}) state_q <= S_DONE;
        end
        S_DONE: begin
          y_q       <= '0;
          y_valid_q <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign Y       = y_q;
  assign y_valid = y_valid_q;
  assign done    = done_q;
  assign count   = count_q;

endmodule
`default_nettype wire

// File: doc/sng_array.md
Name: sng_array

Overview:
- Parametrised multi-channel stochastic number generator with a built-in per-channel de-randomizing counter.
- Each channel converts an N-bit binary operand into a unipolar bitstream: a maximal-length Fibonacci LFSR compared against the latched operand.
- A start/busy/done handshake controls runs of programmable stream length.
- Feeds stochastic arithmetic datapaths. The counters give an exact binary readback for self-check.

Parameters:
- N, 10, operand/LFSR width in bits.
- CH, 2, number of independent channels.
- TAPS, 10'h240, N-bit feedback tap mask (default = x^10+x^7+1, maximal length).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- A  in  CH*N  operands, channel c at [c*N +: N].
- seed  in  CH*N  LFSR seeds, channel c at [c*N +: N].
- len  in  N  stream length L; 0 means full period 2^N-1.
- busy  out  1  high from the start-accept edge until done deasserts.
- Y  out  CH  stochastic bits, one per channel.
- y_valid  out  1  Y qualifier.
- done  out  1  one-cycle pulse at end of run.
- count  out  CH*N  per-channel number of ones in the run.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, state is IDLE, all LFSR/operand/length registers are 0.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
- LFSR step: fb = XOR-reduce(lfsr & TAPS); next = {lfsr[N-2:0], fb}.
- Compare: cmp_c = (lfsr_c <= A_c), unsigned, where A_c is the latched operand.
  - The LFSR is never 0, so over a full period the count equals exactly A_c.
- Edge E0 (IDLE and start=1):
  - Latch A and L (len 0 -> 2^N-1).
  - Load lfsr_c = seed_c; a seed of 0 is substituted with 1.
  - Clear count; set busy=1; go to RUN.
- Edges E1..EL (RUN), per edge:
  - Y_c <= cmp_c; y_valid <= 1.
  - lfsr_c <= next; count_c <= count_c + cmp_c.
  - Remaining counter decrements. At EL, go to DONE.
- Edge E(L+1) (DONE):
  - y_valid <= 0; Y <= 0; done <= 1.
  - count holds its final value (already final from EL).
  - Go to IDLE.
- Edge E(L+2): done <= 0, busy <= 0.
- Cycle accounting: exactly L y_valid cycles, and busy is high for L+2 cycles.
- Count width is N bits and cannot overflow, since L <= 2^N-1.
- count holds its value until the next accepted start.
- start while busy is ignored (not queued).
- A, seed and len changing during RUN have no effect.
- Reset asserted mid-run aborts immediately: no done pulse, count = 0.
- A = 0 gives an all-zero stream; A = 2^N-1 gives an all-one stream.

Optional Feature:
- Macro: SNG_SHARED_LFSR_EN.
- Defined:
  - A single LFSR is seeded from channel 0's seed; the other seeds are ignored.
  - Channel c compares A_c against the shared LFSR value rotated left by c bits.
  - Rotation is a bijection on nonzero values, so full-period counts remain exactly A_c.
  - Saves (CH-1)*N flops.
- Undefined: CH independent LFSRs, each with its own seed.

Test Plan:
1. N=10, CH=2, A0=575, seed0=0x008, A1=100, seed1=0x2A5, len=0, start pulse -> 1023 y_valid cycles, single done pulse, count0=575, count1=100, busy high for 1025 cycles.
2. A0=0, A1=1023, len=0 -> Y0 constantly 0, Y1 constantly 1 while y_valid; counts 0 and 1023.
3. seed0=0 versus seed0=1, same A0=300, len=64 -> identical Y0 sequences and identical count0.
4. len=16, start held high through the run plus an extra start pulse at cycle 5 -> exactly 16 y_valid cycles, one done, busy drops at cycle 18, immediate restart only on a start seen in IDLE.
5. rst driven low at cycle 200 of a full run -> Y, y_valid, busy, done, count become 0 without waiting for a clock edge; after release, a new run with test-1 stimulus gives 575/100.
6. Build with SNG_SHARED_LFSR_EN, test-1 stimulus -> count0=575, count1=100; Y1 matches a reference model of rotl(lfsr,1) <= 100.
